// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed when the
// operation is accepted and committed after a fixed latency; Busy covers that window.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        Start,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        dbg_state
);
    // Handshake: Start is the valid strobe and !Busy is ready. An operation is
    // accepted only on an edge where Start=1 and the unit is IDLE; anything else is dropped.
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [31:0]        res_hi, res_lo;
    logic [31:0]        calc_hi, calc_lo;
    logic signed [63:0] a_sx, b_sx, prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] a_s, b_s, quot_s, rem_s;
    logic               accept, is_md, last;

    assign accept = Start && (state == IDLE);
    assign is_md  = (MDOp == OP_MULT) || (MDOp == OP_MULTU) ||
                    (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
    assign last   = (cnt == CW'(1));

    always_comb begin
        a_s    = $signed(A);
        b_s    = $signed(B);
        a_sx   = $signed({{32{A[31]}}, A});
        b_sx   = $signed({{32{B[31]}}, B});
        prod_s = a_sx * b_sx;
        prod_u = {32'b0, A} * {32'b0, B};
        quot_s = a_s / b_s;
        rem_s  = a_s % b_s;
        calc_hi = 32'b0;
        calc_lo = 32'b0;
        case (MDOp)
            OP_MULT:  {calc_hi, calc_lo} = prod_s;
            OP_MULTU: {calc_hi, calc_lo} = prod_u;
            OP_DIV: begin
                // Zero divisor and the single overflowing quotient are defined explicitly
                if (B == 32'b0) begin
                    calc_hi = A;
                    calc_lo = 32'hFFFF_FFFF;
                end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    calc_hi = 32'b0;
                    calc_lo = 32'h8000_0000;
                end else begin
                    calc_hi = rem_s;
                    calc_lo = quot_s;
                end
            end
            OP_DIVU: begin
                if (B == 32'b0) begin
                    calc_hi = A;
                    calc_lo = 32'hFFFF_FFFF;
                end else begin
                    calc_hi = A % B;
                    calc_lo = A / B;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_md) state_next = RUN;
            RUN:     if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy      = (state == RUN);
        dbg_state = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            res_hi <= 32'b0;
            res_lo <= 32'b0;
            HI     <= 32'b0;
            LO     <= 32'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                case (MDOp)
                    OP_MULT, OP_MULTU: begin
                        res_hi <= calc_hi;
                        res_lo <= calc_lo;
                        cnt    <= CW'(MULT_CYCLES);
                    end
                    OP_DIV, OP_DIVU: begin
                        res_hi <= calc_hi;
                        res_lo <= calc_lo;
                        cnt    <= CW'(DIV_CYCLES);
                    end
                    OP_MTHI: HI <= A;
                    OP_MTLO: LO <= A;
                    default: ;
                endcase
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (last) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases from the op definitions
// plus randomized operations checked against a 64-bit arithmetic model.
module tb_mul_div_unit;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = 32'b0, B = 32'b0;
    logic [3:0]  MDOp = 4'd0;
    logic        Start = 1'b0;
    logic [31:0] HI, LO;
    logic        Busy, dbg_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_hi = 32'b0, exp_lo = 32'b0;

    mul_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
        .HI(HI), .LO(LO), .Busy(Busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: {HI, LO} from plain 64-bit arithmetic on the operands.
    function automatic logic [63:0] model_calc(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            4'd1: begin q = sa * sb; return q; end
            4'd2: begin p = ua * ub; return p; end
            4'd3: begin
                if (b == 32'b0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'b0) return {a, 32'hFFFF_FFFF};
                p = ua / ub;
                ua = ua % ub;
                return {ua[31:0], p[31:0]};
            end
            default: return 64'b0;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expected, input bit poke, input string name);
        int n;
        int lat;
        logic [63:0] got;
        logic [63:0] want;
        lat = (op == 4'd1 || op == 4'd2) ? MULT_CYCLES : DIV_CYCLES;
        exp_q.push_back(expected);
        @(negedge clk);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0; MDOp = 4'($urandom_range(0, 15)); A = $urandom; B = $urandom;
        checks++;
        if (Busy !== 1'b1 || dbg_state !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_rise: Busy=%b state=%b required 1/1", name, Busy, dbg_state);
        end
        n = 0;
        while (Busy === 1'b1 && n < 60) begin
            checks++;
            if (HI !== exp_hi || LO !== exp_lo) begin
                errors++;
                $display("FAIL %s hold_while_busy: HI=%h LO=%h required %h %h",
                         name, HI, LO, exp_hi, exp_lo);
            end
            // Ignored starts during the busy window, including the edge where Busy falls
            if (poke) begin
                Start = 1'b1; MDOp = 4'($urandom_range(1, 6)); A = $urandom; B = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        Start = 1'b0;
        want = exp_q.pop_front();
        got = {HI, LO};
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, n, lat);
        end
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s result: HI=%h LO=%h required HI=%h LO=%h",
                     name, got[63:32], got[31:0], want[63:32], want[31:0]);
        end
        exp_hi = want[63:32];
        exp_lo = want[31:0];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if (HI !== 32'b0 || LO !== 32'b0 || Busy !== 1'b0 || dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: HI=%h LO=%h Busy=%b state=%b required 0/0/0/0",
                     HI, LO, Busy, dbg_state);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult();
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1'b0, "mult_neg");
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0, "multu_max");
    endtask

    task automatic test_div();
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, "div_neg");
        run_op(4'd4, 32'd7, 32'd2, {32'd1, 32'd3}, 1'b0, "divu_basic");
        run_op(4'd4, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b0, "divu_by_zero");
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, "div_overflow");
        run_op(4'd3, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 1'b0, "div_by_zero");
    endtask

    task automatic test_mthi_mtlo();
        bit busy_seen;
        busy_seen = 1'b0;
        @(negedge clk);
        Start = 1'b1; MDOp = 4'd5; A = 32'h1234_5678;
        @(posedge clk); #1;
        busy_seen |= Busy;
        checks++;
        if (HI !== 32'h1234_5678 || LO !== exp_lo) begin
            errors++;
            $display("FAIL mthi: HI=%h LO=%h required %h %h", HI, LO, 32'h1234_5678, exp_lo);
        end
        MDOp = 4'd6; A = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        busy_seen |= Busy;
        Start = 1'b0;
        checks++;
        if (HI !== 32'h1234_5678 || LO !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL mtlo: HI=%h LO=%h required %h %h", HI, LO, 32'h1234_5678, 32'h9ABC_DEF0);
        end
        @(posedge clk); #1;
        busy_seen |= Busy;
        checks++;
        if (busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL mthi_mtlo_busy: Busy rose, required 0");
        end
        exp_hi = 32'h1234_5678;
        exp_lo = 32'h9ABC_DEF0;
    endtask

    task automatic test_busy_ignore();
        logic [31:0] a, b;
        a = $urandom; b = $urandom_range(1, 1000);
        run_op(4'd4, a, b, model_calc(4'd4, a, b), 1'b1, "divu_poked");
        a = $urandom; b = $urandom;
        run_op(4'd1, a, b, model_calc(4'd1, a, b), 1'b1, "mult_poked");
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(1, 4));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'b0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 9);
                default: ;
            endcase
            run_op(op, a, b, model_calc(op, a, b), bit'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        Start = 1'b1; MDOp = 4'd3; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        Start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        Start = 1'b1; MDOp = 4'd1; A = 32'd1; B = 32'd1;
        @(posedge clk); #1;
        Start = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (HI !== 32'b0 || LO !== 32'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: HI=%h LO=%h Busy=%b required 0/0/0", HI, LO, Busy);
        end
        exp_hi = 32'b0;
        exp_lo = 32'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (DIV_CYCLES) @(posedge clk);
        #1;
        checks++;
        if (HI !== 32'b0 || LO !== 32'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL no_commit_after_abort: HI=%h LO=%h Busy=%b required 0/0/0", HI, LO, Busy);
        end
        run_op(4'd1, 32'd4, 32'd5, {32'd0, 32'd20}, 1'b0, "mult_after_reset");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit for the P5/P6 pipelined MIPS datapath; sits in EX beside the single-cycle ALU and owns the HI/LO registers.
- The single-cycle ALU returns its result in the same cycle. This block is the latency-bearing counterpart: it accepts an operation with a one-cycle Start strobe, reports Busy for a fixed number of cycles, then commits HI/LO.
- Hazard logic stalls mfhi/mflo and further mult/div while Busy or Start is high.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for mult/multu (>=1)
DIV_CYCLES, 10, cycles Busy stays high for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
B  input  32  operand rt (divisor / multiplier)
MDOp  input  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo; other codes = none
Start  input  1  one-cycle strobe qualifying MDOp
HI  output  32  HI register
LO  output  32  LO register
Busy  output  1  operation in flight

Behaviour:
- Reset (async, active-high): HI=0, LO=0, Busy=0, counter=0, state IDLE. Asserting reset mid-operation aborts the operation. No commit occurs, and the unit is IDLE after reset releases.
- States: IDLE, RUN.
- IDLE, rising edge with Start=1:
  - MDOp mult/multu/div/divu: latch A, B and op; compute the result into internal registers; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; Busy=1 from this edge.
  - MDOp mthi: HI<=A at this edge.
  - MDOp mtlo: LO<=A at this edge.
  - In both mthi and mtlo cases, Busy stays 0 and the state stays IDLE.
- IDLE with Start=0 or MDOp=none: no change.
- RUN: the counter decrements each edge. At the edge where the counter reaches 0, commit HI/LO, set Busy=0 and return to IDLE.
- Busy timing: Busy is high for exactly N cycles, with N = MULT_CYCLES or DIV_CYCLES. If Start is sampled at edge k, Busy rises at edge k and falls at edge k+N. The new HI/LO are visible after edge k+N, in the same cycle Busy reads 0.
- Start while Busy=1 (any MDOp, including mthi/mtlo) is ignored. There is no queueing and no effect on the in-flight operation. Upstream guarantees this does not occur; the block must still be robust to it.
- Start in the cycle Busy falls: not possible to be accepted that edge. The first acceptance is the following edge, since Busy is registered and the unit is IDLE only after edge k+N.
- Operands are latched at Start. Changes on A/B during RUN have no effect.
- mult: 64-bit signed product. multu: unsigned product. HI=product[63:32], LO=product[31:0].
- div: signed, truncating toward zero. LO=quotient; HI=remainder, which takes the dividend's sign. divu: unsigned.
- Divide by zero (B=0): LO=32'hFFFFFFFF, HI=A, for both div and divu.
- Signed overflow, div with A=32'h80000000 and B=32'hFFFFFFFF: LO=32'h80000000, HI=0.
- HI and LO hold their values indefinitely between writes.
- HI and LO are written only by a commit, mthi or mtlo.
- The implementation may compute with `*`, `/` and `%` at latch time and delay the commit; a shift-subtract datapath is permitted if externally cycle-identical.

Test Plan:
- Reset, then mult with A=32'hFFFFFFFE (-2), B=3, Start for 1 cycle -> Busy high exactly 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA; HI/LO unchanged while Busy.
- multu with A=32'hFFFFFFFF, B=32'hFFFFFFFF -> after 5 cycles HI=32'hFFFFFFFE, LO=32'h00000001.
- div with A=-7 (32'hFFFFFFF9), B=2 -> Busy 10 cycles, LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. divu with A=7, B=2 -> LO=3, HI=1.
- Corner cases:
  - divu with A=5, B=0 -> LO=32'hFFFFFFFF, HI=5.
  - div with A=32'h80000000, B=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- mthi A=32'h12345678 then mtlo A=32'h9ABCDEF0 on consecutive cycles -> HI/LO update one edge after each Start, Busy never rises.
- Start div at t0; at t0+3, Start mult A=1, B=1 (ignored); at t0+4, assert reset -> HI=LO=0, Busy=0 immediately. After release, Start mult A=4, B=5 -> LO=20, HI=0 after 5 cycles.
